// File: rtl/kamus_csr_ctrl.sv
// kamus_csr_ctrl: machine-mode CSR file with a single-outstanding access sequencer.
// Define KAMUS_MTIMECMP_EN to add the 64-bit mtimecmp compare at 0x7C0/0x7C1.
module kamus_csr_ctrl #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_nowrite_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  localparam logic [31:0] IrqMask = 32'h0000_0888;
  localparam logic [31:0] Misa    = 32'h4000_0100;

  typedef enum logic [0:0] {StIdle, StResp} state_e;
  state_e state_q, state_d;

  logic        mstatus_mie_q, mstatus_mie_d, mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d, irq_pending_q, irq_pending_d;
  logic [31:0] mstatus_val, mip_val, csr_rdata, wval;
  logic        accept, known, ro_space, wr_attempt, err, do_wr, mtip;

`ifdef KAMUS_MTIMECMP_EN
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;
  assign mtip = mtip_q;
`else
  assign mtip = 1'b0;
`endif

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign accept        = req_valid_i & req_ready_o;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign irq_pending_o = irq_pending_q;
  assign mtvec_o       = {mtvec_q[31:2], 2'b00};
  assign mepc_o        = {mepc_q[31:2], 2'b00};

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_val     = {20'b0, irq_ext_i, 3'b0, mtip, 3'b0, irq_sw_i, 3'b0};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    csr_rdata = 32'd0;
    known     = 1'b1;
    case (req_addr_i)
      12'h300: csr_rdata = mstatus_val;
      12'h301: csr_rdata = Misa;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_val;
      12'hF11, 12'hF12, 12'hF13: csr_rdata = 32'd0;
      12'hF14: csr_rdata = HART_ID;
      12'hB00, 12'hC00, 12'hC01: csr_rdata = cycle_q[31:0];
      12'hB80, 12'hC80, 12'hC81: csr_rdata = cycle_q[63:32];
      12'hB02, 12'hC02: csr_rdata = instret_q[31:0];
      12'hB82, 12'hC82: csr_rdata = instret_q[63:32];
`ifdef KAMUS_MTIMECMP_EN
      12'h7C0: csr_rdata = mtimecmp_q[31:0];
      12'h7C1: csr_rdata = mtimecmp_q[63:32];
`endif
      default: known = 1'b0;
    endcase
  end

  // RS/RC with rs1=x0 never counts as a write, so it is legal on read-only CSRs.
  assign ro_space   = (req_addr_i[11:10] == 2'b11);
  assign wr_attempt = (req_op_i == 2'd0) | ~req_nowrite_i;
  assign err        = (req_op_i == 2'd3) | ~known | (ro_space & wr_attempt);
  assign do_wr      = accept & ~err & wr_attempt;

  always_comb begin
    case (req_op_i)
      2'd0:    wval = req_wdata_i;
      2'd1:    wval = csr_rdata | req_wdata_i;
      default: wval = csr_rdata & ~req_wdata_i;
    endcase
  end

  always_comb begin
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    cycle_d       = cycle_q + 64'd1;
    instret_d     = instret_q + {63'd0, retire_i};
`ifdef KAMUS_MTIMECMP_EN
    mtimecmp_d    = mtimecmp_q;
`endif
    if (do_wr) begin
      case (req_addr_i)
        12'h300: begin
          mstatus_mie_d = wval[3];
          mpie_d        = wval[7];
        end
        12'h304: mie_d      = wval & IrqMask;
        12'h305: mtvec_d    = {wval[31:2], 2'b00};
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval;
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
        12'hB00: cycle_d    = {cycle_q[63:32], wval};
        12'hB80: cycle_d    = {wval, cycle_q[31:0]};
        12'hB02: instret_d  = {instret_q[63:32], wval};
        12'hB82: instret_d  = {wval, instret_q[31:0]};
`ifdef KAMUS_MTIMECMP_EN
        12'h7C0: mtimecmp_d = {mtimecmp_q[63:32], wval};
        12'h7C1: mtimecmp_d = {wval, mtimecmp_q[31:0]};
`endif
        default: ;
      endcase
    end
    // Trap overrides mret, which overrides a same-cycle CSR write.
    if (mret_i) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
    end
    if (trap_i) begin
      mepc_d        = trap_pc_i;
      mcause_d      = trap_cause_i;
      mtval_d       = trap_tval_i;
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
    end
  end

  assign rdata_d       = accept ? ((known && req_op_i != 2'd3) ? csr_rdata : 32'd0) : rdata_q;
  assign err_d         = accept ? err : err_q;
  assign irq_pending_d = mstatus_mie_q & |(mip_val & mie_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      rdata_q       <= 32'd0;
      err_q         <= 1'b0;
      irq_pending_q <= 1'b0;
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mie_q         <= 32'd0;
      mtvec_q       <= {MTVEC_RST[31:2], 2'b00};
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      cycle_q       <= 64'd0;
      instret_q     <= 64'd0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      irq_pending_q <= irq_pending_d;
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      cycle_q       <= cycle_d;
      instret_q     <= instret_d;
    end
  end

`ifdef KAMUS_MTIMECMP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (cycle_q >= mtimecmp_q);
    end
  end
`endif

endmodule

// File: doc/kamus_csr_ctrl.md
Name: kamus_csr_ctrl

Overview: Machine-mode CSR file and access sequencer for the kamus-v core. Accepts CSRRW/CSRRS/CSRRC requests from the execute stage and returns read data one cycle later. Owns the cycle/instret counters, trap entry and mret state, and interrupt-pending generation. Supplies mtvec/mepc to the fetch redirect logic.

Parameters:
HART_ID, 0, value returned by MHARTID (0xF14).
MTVEC_RST, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  CSR access request
req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
req_op_i  in  2  0=RW, 1=RS, 2=RC, 3=reserved (treated as illegal)
req_addr_i  in  12  CSR address
req_wdata_i  in  32  rs1 value or zimm
req_nowrite_i  in  1  rs1=x0/zimm=0 on RS/RC: read only, no write side effect
rsp_valid_o  out  1  response valid, one cycle pulse
rsp_rdata_o  out  32  old CSR value
rsp_err_o  out  1  illegal access (unknown address, write to read-only, op=3)
retire_i  in  1  one instruction retired this cycle
trap_i  in  1  synchronous trap or interrupt being taken
trap_cause_i  in  32  mcause value to record
trap_pc_i  in  32  pc to store in mepc
trap_tval_i  in  32  value to store in mtval (0x343)
mret_i  in  1  mret executing
irq_ext_i  in  1  external interrupt level (mip.meip)
irq_sw_i  in  1  software interrupt level (mip.msip)
mtvec_o  out  32  {mtvec[31:2],2'b0}
mepc_o  out  32  {mepc[31:2],2'b0}
irq_pending_o  out  1  mstatus.mie & |(mip & mie)

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; counters=0; mstatus.mie/mpie=0; mie=0; mscratch/mepc/mcause/mtval=0; mtvec=MTVEC_RST; irq_pending_o=0.
- FSM: IDLE -> RESP on req_valid_i&req_ready_o; RESP -> IDLE unconditionally. req_ready_o=1 only in IDLE; one outstanding access. rsp_valid_o=1 only in RESP.
- Acceptance edge: old value captured into rsp_rdata_o; write committed on the same edge. New value = wdata (RW), old|wdata (RS), old&~wdata (RC). No write when req_nowrite_i=1 on RS/RC; RW always writes.
- Read-only space addr[11:10]==2'b11: read legal; write attempt -> rsp_err_o=1, no state change, rdata still returned. Unknown address or op=3 -> rsp_err_o=1, rdata=0, no write.
- Field masking: mstatus reads {19'b0,2'b11,3'b0,mpie,3'b0,mie,3'b0}; only mie(bit3)/mpie(bit7) writable. mie/mip expose bits 3/7/11; mip.msip/meip read-only from irq inputs. misa=32'h4000_0100. mvendorid/marchid/mimpid=0.
- Counters: 64-bit cycle increments every cycle; instret increments when retire_i. Low-to-high carry on 0xFFFF_FFFF, full 64-bit wrap to 0. Write to MCYCLE(H)/MINSTRET(H) (0xB00/0xB80/0xB02/0xB82) replaces that half and suppresses the increment in that cycle. CYCLE/TIME (0xC00/0xC01) read the low half of cycle; CYCLEH/TIMEH (0xC80/0xC81) the high half; INSTRET(H) 0xC02/0xC82.
- Trap (trap_i): mepc<=trap_pc_i, mcause<=trap_cause_i, mtval<=trap_tval_i, mpie<=mie, mie<=0. Trap has priority over a same-cycle CSR write to the same registers; the CSR response still completes normally with the old value.
- mret_i: mie<=mpie, mpie<=1. trap_i and mret_i together: trap wins.
- irq_pending_o is registered; it reflects the state one cycle after any change.

Optional Feature:
KAMUS_MTIMECMP_EN: defined -> 64-bit mtimecmp at CSR 0x7C0 (low) / 0x7C1 (high), reset all-ones. mip.mtip (bit7) = (cycle >= mtimecmp) is registered and folded into irq_pending_o. Undefined -> 0x7C0/0x7C1 are illegal addresses (rsp_err_o=1), and mip.mtip reads 0.

Test Plan:
- Reset then RS read 0x301 with nowrite -> one cycle later rsp_valid_o=1, rdata=0x4000_0100, err=0; req_ready_o low during RESP.
- RW 0x340 with 0xDEAD_BEEF, then RC 0x340 with 0x0000_00FF -> second rdata=0xDEAD_BEEF; subsequent read=0xDEAD_BE00.
- RW 0xB00 with 0xFFFF_FFFE, then idle 3 cycles -> read 0xB80 returns 1 and 0xB00 returns the small wrapped count; write to 0xC00 -> err=1, counter unchanged.
- Set mie bit11 and mstatus.mie, raise irq_ext_i -> irq_pending_o=1 next cycle; trap_i with pc 0x104, cause 0x8000_000B -> mepc_o=0x104, mstatus.mie=0, mpie=1; mret_i -> mie=1.
- trap_i on the same edge as an RW to 0x341 with 0x200 -> mepc=trap_pc_i, response rdata = old mepc.
- KAMUS_MTIMECMP_EN: write mtimecmp=20, mie.mtie=1, mstatus.mie=1 -> irq_pending_o rises once cycle>=20; without the macro, access to 0x7C0 -> err=1.
